mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative multiply/divide unit for the MIPS execute stage. It takes the same SrcA/SrcB operands the ALU receives from the register file and computes mult, multu, div and divu over 32 iterations into architectural HI/LO registers. mfhi/mflo read HI/LO through the write-back mux, and mthi/mtlo write them directly. The controller stalls the pipeline while busy is high.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- start  input  1  launch operation; sampled only in IDLE
- md_op  input  2  00 mult, 01 multu, 10 div, 11 divu
- SrcA  input  WIDTH  multiplicand / dividend
- SrcB  input  WIDTH  multiplier / divisor
- hi_we  input  1  mthi write strobe
- lo_we  input  1  mtlo write strobe
- wdata  input  WIDTH  mthi/mtlo data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: HI/LO just updated by an operation
- div_by_zero  output  1  last div/divu had SrcB==0; cleared by next accepted start
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

## Operation
- States: IDLE, RUN, FIX. Reset puts the block in IDLE. Reset values: busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
- IDLE, start=1:
  - Capture md_op, the sign of SrcA and the sign of SrcB.
  - Capture |SrcA| and |SrcB| for signed ops; raw values for unsigned ops.
  - Go to RUN with counter=0.
- IDLE, start=0: hi_we loads hi←wdata and lo_we loads lo←wdata. Both strobes may be active in the same cycle.
- RUN, one iteration per cycle, counter 0..31; after counter==31, go to FIX:
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring divide. Shift remainder:quotient left, trial-subtract the divisor, set the quotient bit on non-negative result.
- FIX, one cycle, then back to IDLE:
  - Multiply, signed, signs differ: negate the 64-bit product. Then {hi,lo}←product.
  - Divide, signed: quotient negated if the signs differ; remainder takes the sign of the dividend. Then lo←quotient, hi←remainder.
  - Asserts done for the cycle after the FIX edge.
- Divide by zero (SrcB==0): still runs the full 33 cycles. Result is lo=0xFFFFFFFF, hi=dividend as presented (SrcA, unmodified) for both div and divu. Sets div_by_zero.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of magnitude arithmetic plus wrap-around negation, with no special case.
- Multiplication never overflows: the full 64-bit result is always kept.

## Timing
- Latency:
  - start is accepted at edge N.
  - Iterations run at edges N+1..N+32.
  - HI/LO are written at edge N+33.
  - done is high during the cycle after N+33.
- busy is high from the cycle after edge N through the cycle ending at edge N+33, i.e. 33 cycles.
- A new start may be accepted on the same cycle that done is high, because the state is already IDLE.
- start while busy: ignored, with no queueing.
- hi_we/lo_we while busy: ignored. The controller must not issue mthi/mtlo while stalled.
- start and hi_we/lo_we in the same IDLE cycle: start wins and the writes are dropped.
- Reset mid-operation: immediate return to IDLE and all outputs go to their reset values. The partial result is discarded.
- hi/lo change only at an mthi/mtlo write edge or the FIX edge.

## Structure
- Shared package mdu_pkg holds:
  - MD_MULT, MD_MULTU, MD_DIV, MD_DIVU encodings.
  - The IDLE/RUN/FIX state encoding.
  - WIDTH=32.
  - Iteration count ITERS=32.
- Natural sub-module: mdu_sign_fix, combinational. It takes the result plus the captured signs and op, and produces final HI/LO. This keeps the FIX logic out of the FSM.
- The datapath registers live in mul_div_unit: 64-bit accumulator/remainder, 32-bit divisor/multiplicand, 5-bit counter.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. done exactly 33 cycles after start is accepted; busy high for 33 cycles.
- mult 0xFFFFFFFD (−3) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; mult 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- div 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/2 → lo=3, hi=1; div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- divu 5/0 → lo=0xFFFFFFFF, hi=5, div_by_zero=1. A following multu 2×3 clears div_by_zero and gives lo=6, hi=0.
- During busy: start with different operands and hi_we with 0x1234 are both ignored, and the original result lands. In IDLE, lo_we with wdata=0xCAFEF00D gives lo=0xCAFEF00D on the next cycle. start+hi_we together: only start takes effect.
- Reset asserted asynchronously 10 cycles into a divu: busy, done, hi, lo and div_by_zero go to 0 immediately. After release, a fresh multu 3×4 yields lo=12 with normal 33-cycle latency.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = 32;
    localparam int CNT_W = $clog2(ITERS);

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_t;

    function automatic logic is_div(md_op_t op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(md_op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Operand, HI/LO write and result bundle between the execute-stage controller and the unit.
interface mul_div_unit_if
    import mdu_pkg::*;
();
    logic             start;
    md_op_t           md_op;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, md_op, SrcA, SrcB, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, md_op, SrcA, SrcB, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mdu_sign_fix.sv
// Turns the magnitude result of the iteration loop into architectural HI/LO values.
module mdu_sign_fix
    import mdu_pkg::*;
(
    input  md_op_t             op,
    input  logic               sign_a,
    input  logic               sign_b,
    input  logic               div_zero,
    input  logic [2*WIDTH-1:0] result,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);
    logic               neg;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        neg  = is_signed_op(op) && (sign_a ^ sign_b);
        prod = neg ? -result : result;
        quot = result[WIDTH-1:0];
        rem  = result[2*WIDTH-1:WIDTH];
        if (neg) quot = -quot;
        if (is_signed_op(op) && sign_a) rem = -rem;
        // A zero divisor leaves the dividend in the remainder; only the quotient is forced.
        if (div_zero) quot = '1;
        if (is_div(op)) begin
            hi = rem;
            lo = quot;
        end else begin
            hi = prod[2*WIDTH-1:WIDTH];
            lo = prod[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle mult/multu/div/divu with architectural HI/LO registers.
//   state  | meaning
//   S_IDLE | waiting for start; mthi/mtlo writes accepted
//   S_RUN  | one shift-add or restoring-divide step per cycle
//   S_FIX  | sign correction, HI/LO update
module mul_div_unit
    import mdu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mul_div_unit_if.slave bus
);
    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   counter;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opnd;
    md_op_t             op_q;
    logic               sign_a;
    logic               sign_b;
    logic               dz_q;
    logic               dz_flag;
    logic               done_q;
    logic               busy;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;
    logic               signed_op;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic               last_iter;

    assign signed_op = is_signed_op(bus.md_op);
    assign mag_a     = (signed_op && bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
    assign mag_b     = (signed_op && bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;
    assign last_iter = (counter == CNT_W'(ITERS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = S_RUN;
            S_RUN:   if (last_iter) state_nx = S_FIX;
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    // The trial compare uses 33 bits: the shifted remainder can exceed 32 bits before subtracting.
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_ge  = acc[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd};
        div_sub = acc[2*WIDTH-2:WIDTH-1] - opnd;
        if (is_div(op_q))
            acc_step = div_ge ? {div_sub, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
        else
            acc_step = {mul_sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= '0;
            acc     <= '0;
            opnd    <= '0;
            op_q    <= MD_MULT;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            dz_q    <= 1'b0;
            dz_flag <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= (state == S_FIX);
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.md_op;
                        sign_a  <= bus.SrcA[WIDTH-1];
                        sign_b  <= bus.SrcB[WIDTH-1];
                        counter <= '0;
                        dz_flag <= 1'b0;
                        dz_q    <= is_div(bus.md_op) && (bus.SrcB == '0);
                        if (is_div(bus.md_op)) begin
                            acc  <= {{WIDTH{1'b0}}, mag_a};
                            opnd <= mag_b;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, mag_b};
                            opnd <= mag_a;
                        end
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wdata;
                        if (bus.lo_we) lo_q <= bus.wdata;
                    end
                end
                S_RUN: begin
                    acc     <= acc_step;
                    counter <= counter + 1'b1;
                end
                S_FIX: begin
                    hi_q    <= hi_fix;
                    lo_q    <= lo_fix;
                    dz_flag <= dz_q;
                end
                default: ;
            endcase
        end
    end

    mdu_sign_fix u_sign_fix (
        .op       (op_q),
        .sign_a   (sign_a),
        .sign_b   (sign_b),
        .div_zero (dz_q),
        .result   (acc),
        .hi       (hi_fix),
        .lo       (lo_fix)
    );

    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_flag;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO from a behavioural model, checked on done.
module tb_mul_div_unit;
    import mdu_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb_, p, q, r;
        logic [63:0] up;
        e  = '0;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        case (op)
            MD_MULT: begin
                p = sa * sb_;
                {e.hi, e.lo} = p;
            end
            MD_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                {e.hi, e.lo} = up;
            end
            MD_DIV: begin
                if (b == 0) begin
                    e.lo = 32'hFFFFFFFF; e.hi = a; e.dz = 1'b1;
                end else begin
                    q = sa / sb_; r = sa % sb_;
                    e.lo = q[31:0]; e.hi = r[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    e.lo = 32'hFFFFFFFF; e.hi = a; e.dz = 1'b1;
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic interfere, input logic with_we);
        exp_t e;
        int   cyc;
        int   bcnt;
        logic got;
        sb.push_back(model(op, a, b));
        bus.start = 1'b1; bus.md_op = op; bus.SrcA = a; bus.SrcB = b;
        if (with_we) begin bus.hi_we = 1'b1; bus.wdata = 32'hDEAD0000; end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.hi_we = 1'b0;
        if (with_we) chk("we_with_start_dropped", bus.hi, cur_hi);
        bcnt = bus.busy ? 1 : 0;
        cyc  = 0;
        got  = 1'b0;
        while (!got && cyc < 40) begin
            if (interfere && cyc == 5) begin
                bus.start = 1'b1; bus.md_op = MD_MULTU; bus.SrcA = 32'd9; bus.SrcB = 32'd9;
                bus.hi_we = 1'b1; bus.wdata = 32'h1234;
            end else if (interfere && cyc == 6) begin
                bus.start = 1'b0; bus.hi_we = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (bus.busy) bcnt++;
            if (bus.done) got = 1'b1;
        end
        chk("done_seen", got, 1);
        e = sb.pop_front();
        chk("hi", bus.hi, e.hi);
        chk("lo", bus.lo, e.lo);
        chk("div_by_zero", bus.div_by_zero, e.dz);
        chk("latency", cyc, 33);
        chk("busy_cycles", bcnt, 33);
        cur_hi = e.hi;
        cur_lo = e.lo;
        @(posedge clk); #1;
        chk("done_one_cycle", bus.done, 0);
        chk("hi_stable", bus.hi, cur_hi);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.start = 1'b0; bus.md_op = MD_MULT; bus.SrcA = '0; bus.SrcB = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        cur_hi = '0; cur_lo = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_dz", bus.div_by_zero, 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);

        run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(MD_MULT,  32'hFFFFFFFD, 32'd7,        1'b0, 1'b0);
        run_op(MD_MULT,  32'h80000000, 32'h80000000, 1'b0, 1'b0);
        run_op(MD_DIV,   32'hFFFFFFF9, 32'd2,        1'b0, 1'b0);
        run_op(MD_DIVU,  32'd7,        32'd2,        1'b0, 1'b0);
        run_op(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(MD_DIVU,  32'd5,        32'd0,        1'b0, 1'b0);
        run_op(MD_MULTU, 32'd2,        32'd3,        1'b0, 1'b0);
        run_op(MD_DIV,   32'd100,      32'hFFFFFFFD, 1'b1, 1'b0);
        run_op(MD_DIV,   32'hFFFFFFF9, 32'd0,        1'b0, 1'b0);

        bus.lo_we = 1'b1; bus.wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.lo_we = 1'b0;
        chk("mtlo_lo", bus.lo, 32'hCAFEF00D);
        chk("mtlo_hi_kept", bus.hi, cur_hi);
        cur_lo = 32'hCAFEF00D;

        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h5A5A1234;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        chk("both_we_hi", bus.hi, 32'h5A5A1234);
        chk("both_we_lo", bus.lo, 32'h5A5A1234);
        cur_hi = 32'h5A5A1234; cur_lo = 32'h5A5A1234;

        run_op(MD_MULTU, 32'd2, 32'd3, 1'b0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom;
            run_op(md_op_t'(i % 4), ra, rb, 1'b0, 1'b0);
        end

        sb.push_back(model(MD_DIVU, 32'd1000, 32'd7));
        bus.start = 1'b1; bus.md_op = MD_DIVU; bus.SrcA = 32'd1000; bus.SrcB = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_hi", bus.hi, 0);
        chk("midrst_lo", bus.lo, 0);
        chk("midrst_dz", bus.div_by_zero, 0);
        void'(sb.pop_back());
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cur_hi = '0; cur_lo = '0;
        run_op(MD_MULTU, 32'd3, 32'd4, 1'b0, 1'b0);
        chk("post_rst_lo", bus.lo, 32'd12);

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
